// File: rtl/serial_parity_pkg.sv
// -----------------------------------------------------------------------------
// serial_parity_pkg
//
// Shared types and constants for the serial parity receive path.
//
// Contents:
//   rx_state_e      - receiver FSM states (idle, start, data, parity, stop, break)
//   FRAME_DATA_BITS - number of data bits carried per frame
//   RX_IDLE_LEVEL   - line level while no frame is in flight
//   even_parity()   - XOR reduction of a data word plus its parity bit
//
// No ports; imported by serial_parity_rx and friends.
// -----------------------------------------------------------------------------
package serial_parity_pkg;

  localparam int unsigned FRAME_DATA_BITS = 4;
  localparam logic        RX_IDLE_LEVEL   = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  // Returns 1 when the data bits plus the parity bit hold an odd number of ones,
  // i.e. when an even-parity frame is corrupt.
  function automatic logic even_parity(input logic [FRAME_DATA_BITS-1:0] data,
                                       input logic                       parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//
// One-bit, two-stage synchronizer for bringing an asynchronous level into the
// clk domain. Both stages reset to RESET_VALUE so that a line which idles at a
// known level does not produce a false edge when reset is released.
//
// Parameters:
//   RESET_VALUE - value loaded into both stages while rst_n is low
//
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   d     - asynchronous input
//   q     - synchronized output, two cycles behind d
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      q      <= RESET_VALUE;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/serial_parity_rx.sv
// -----------------------------------------------------------------------------
// serial_parity_rx
//
// Single-wire asynchronous receiver for a 4-bit nibble plus its even-parity bit.
// Frame on the line (idle high): start(0), d0..d3 LSB first, parity, stop(1).
// The received word is presented in parallel with a one-cycle valid strobe and
// is meant to feed an even parity checker directly (data_out/parity_out into
// its data/parity inputs, valid qualifying its error output).
//
// Parameters:
//   CLKS_PER_BIT - clock cycles per bit period; must be even and >= 4
//
// Ports:
//   clk        - rising-edge clock
//   rst_n      - synchronous active-low reset
//   rx         - asynchronous serial line, idle high
//   data_out   - last good nibble (d3..d0), held until the next good frame
//   parity_out - last good parity bit, held until the next good frame
//   valid      - one-cycle pulse when data_out/parity_out update
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   busy       - high whenever the receiver is not idle
//   parity_err - (only with SERIAL_PARITY_RX_CHECK_EN) XOR of the accepted
//                data and parity, updated with valid and held until the next
//                good frame
//
// Build option:
//   SERIAL_PARITY_RX_CHECK_EN - define to add the parity_err output. Without it
//                               the parity bit is passed through unchecked.
// -----------------------------------------------------------------------------
module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rx,
  output logic [FRAME_DATA_BITS-1:0] data_out,
  output logic                       parity_out,
  output logic                       valid,
  output logic                       frame_err,
  output logic                       busy
`ifdef SERIAL_PARITY_RX_CHECK_EN
  ,
  output logic                       parity_err
`endif
);

  // Bit-period counter runs 0..CLKS_PER_BIT-1 and wraps.
  localparam int unsigned    CntW    = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  // Half a bit period after the start edge lands on the middle of the start bit;
  // every later sample is one full period after that, so all stay mid-bit.
  localparam logic [CntW-1:0] CntMid  = CntW'(CLKS_PER_BIT / 2 - 1);

  localparam int unsigned    IdxW    = $clog2(FRAME_DATA_BITS);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(FRAME_DATA_BITS - 1);

  logic                       rx_s;
  rx_state_e                  state_q;
  logic [CntW-1:0]            cnt_q;
  logic [IdxW-1:0]            idx_q;
  logic [FRAME_DATA_BITS-1:0] shift_q;
  logic                       par_q;

  sync_2ff #(
    .RESET_VALUE(RX_IDLE_LEVEL)
  ) u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  // Receiver FSM. All outputs are registered here; valid and frame_err default
  // low every cycle so they can only ever be single-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      data_out   <= '0;
      parity_out <= 1'b0;
      valid      <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
`ifdef SERIAL_PARITY_RX_CHECK_EN
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;

      unique case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (rx_s != RX_IDLE_LEVEL) begin
            state_q <= StStart;
            busy    <= 1'b1;
          end
        end

        StStart: begin
          if (cnt_q == CntMid) begin
            cnt_q <= '0;
            if (rx_s == 1'b0) begin
              state_q <= StData;
              idx_q   <= '0;
            end else begin
              // Line was high again by mid-bit: a glitch, not a start bit.
              state_q <= StIdle;
              busy    <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (cnt_q == CntLast) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s;
            if (idx_q == IdxLast) begin
              state_q <= StParity;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StParity: begin
          if (cnt_q == CntLast) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StStop: begin
          if (cnt_q == CntLast) begin
            cnt_q <= '0;
            if (rx_s == 1'b1) begin
              data_out   <= shift_q;
              parity_out <= par_q;
              valid      <= 1'b1;
`ifdef SERIAL_PARITY_RX_CHECK_EN
              parity_err <= even_parity(shift_q, par_q);
`endif
              // Back to idle right away so a start bit immediately following
              // the stop bit is still caught.
              state_q    <= StIdle;
              busy       <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state_q   <= StBreak;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StBreak: begin
          // Hold off until the line recovers so a stuck-low line cannot keep
          // looking like fresh start bits.
          if (rx_s == RX_IDLE_LEVEL) begin
            state_q <= StIdle;
            busy    <= 1'b0;
          end
        end

        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Both strobes come from the same stop-bit sample, so they cannot coincide.
  a_strobes_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(valid && frame_err));

  // busy is a registered copy of "not idle".
  a_busy_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state_q != StIdle));

endmodule

// File: tb/tb_serial_parity_rx.sv
module tb_serial_parity_rx;

  localparam int unsigned Cpb = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [3:0] data_out;
  logic       parity_out;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef SERIAL_PARITY_RX_CHECK_EN
  logic       parity_err;
`endif

  serial_parity_rx #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .data_out  (data_out),
    .parity_out(parity_out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef SERIAL_PARITY_RX_CHECK_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Event monitor, sampled on the falling edge away from the active edge.
  int         cyc = 0;
  int         nvalid = 0;
  int         nferr = 0;
  int         nboth = 0;
  int         vcyc_last = 0;
  int         vcyc_prev = 0;
  logic [3:0] vdat_last = 4'h0;
  logic [3:0] vdat_prev = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      nvalid    <= nvalid + 1;
      vcyc_prev <= vcyc_last;
      vcyc_last <= cyc;
      vdat_prev <= vdat_last;
      vdat_last <= data_out;
    end
    if (frame_err) nferr <= nferr + 1;
    if (valid && frame_err) nboth <= nboth + 1;
  end

  // Reference model: outcome of a whole frame from the framing rules alone.
  int         m_nv = 0;
  int         m_nf = 0;
  logic [3:0] m_data = 4'h0;
  logic       m_par = 1'b0;
  logic       m_perr = 1'b0;

  task automatic model_frame(input logic [3:0] d, input logic p, input logic stop);
    if (stop) begin
      m_nv++;
      m_data = d;
      m_par  = p;
      m_perr = (($countones(d) + int'(p)) % 2) != 0;
    end else begin
      m_nf++;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " valid count"}, nvalid, m_nv);
    chk({tag, " frame_err count"}, nferr, m_nf);
    chk({tag, " data_out"}, 32'(data_out), 32'(m_data));
    chk({tag, " parity_out"}, 32'(parity_out), 32'(m_par));
`ifdef SERIAL_PARITY_RX_CHECK_EN
    chk({tag, " parity_err"}, 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    tick(Cpb);
  endtask

  // Start, d0..d3, parity, stop, then gap_bits idle periods. With gap_bits=0
  // the line is left at the stop-bit level.
  task automatic send_frame(input logic [3:0] d, input logic p, input logic stop,
                            input int gap_bits);
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    send_bit(p);
    send_bit(stop);
    if (gap_bits > 0) begin
      rx = 1'b1;
      tick(gap_bits * Cpb);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " data_out"}, 32'(data_out), 32'h0);
    chk({tag, " parity_out"}, 32'(parity_out), 32'h0);
    chk({tag, " valid"}, 32'(valid), 32'h0);
    chk({tag, " frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, " busy"}, 32'(busy), 32'h0);
`ifdef SERIAL_PARITY_RX_CHECK_EN
    chk({tag, " parity_err"}, 32'(parity_err), 32'h0);
`endif
  endtask

  typedef struct {
    logic [3:0] d;
    logic       p;
    logic       stop;
    int         exp_nv;
    int         exp_nf;
    logic [3:0] exp_data;
    logic       exp_par;
    logic       exp_perr;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int         nv0;
    int         nf0;
    logic       saw_busy;
    logic [3:0] rd;
    logic       rp;
    logic       rs;

    vecs[0] = '{d: 4'hB, p: 1'b1, stop: 1'b1, exp_nv: 1, exp_nf: 0,
                exp_data: 4'hB, exp_par: 1'b1, exp_perr: 1'b0};
    vecs[1] = '{d: 4'h6, p: 1'b1, stop: 1'b1, exp_nv: 1, exp_nf: 0,
                exp_data: 4'h6, exp_par: 1'b1, exp_perr: 1'b1};
    vecs[2] = '{d: 4'h3, p: 1'b0, stop: 1'b0, exp_nv: 0, exp_nf: 1,
                exp_data: 4'h6, exp_par: 1'b1, exp_perr: 1'b1};
    vecs[3] = '{d: 4'h0, p: 1'b0, stop: 1'b1, exp_nv: 1, exp_nf: 0,
                exp_data: 4'h0, exp_par: 1'b0, exp_perr: 1'b0};
    vecs[4] = '{d: 4'hF, p: 1'b0, stop: 1'b1, exp_nv: 1, exp_nf: 0,
                exp_data: 4'hF, exp_par: 1'b0, exp_perr: 1'b0};
    vecs[5] = '{d: 4'h9, p: 1'b1, stop: 1'b0, exp_nv: 0, exp_nf: 1,
                exp_data: 4'hF, exp_par: 1'b0, exp_perr: 1'b0};
    vecs[6] = '{d: 4'h8, p: 1'b1, stop: 1'b1, exp_nv: 1, exp_nf: 0,
                exp_data: 4'h8, exp_par: 1'b1, exp_perr: 1'b0};
    vecs[7] = '{d: 4'h7, p: 1'b0, stop: 1'b1, exp_nv: 1, exp_nf: 0,
                exp_data: 4'h7, exp_par: 1'b0, exp_perr: 1'b1};

    rst_n = 1'b0;
    rx    = 1'b1;
    tick(3);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick(2);

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      nv0 = nvalid;
      nf0 = nferr;
      send_frame(vecs[i].d, vecs[i].p, vecs[i].stop, 2);
      model_frame(vecs[i].d, vecs[i].p, vecs[i].stop);
      chk($sformatf("vec%0d valid pulses", i), nvalid - nv0, vecs[i].exp_nv);
      chk($sformatf("vec%0d frame_err pulses", i), nferr - nf0, vecs[i].exp_nf);
      chk($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_data));
      chk($sformatf("vec%0d parity_out", i), 32'(parity_out), 32'(vecs[i].exp_par));
`ifdef SERIAL_PARITY_RX_CHECK_EN
      chk($sformatf("vec%0d parity_err", i), 32'(parity_err), 32'(vecs[i].exp_perr));
`endif
    end

    // Stop bit low, then line stuck low: one frame_err, no retrigger, stays busy.
    send_frame(4'h3, 1'b0, 1'b0, 0);
    model_frame(4'h3, 1'b0, 1'b0);
    rx = 1'b0;
    tick(20);
    check_model("break");
    chk("break busy while low", 32'(busy), 32'h1);
    rx = 1'b1;
    tick(Cpb);
    chk("break busy after release", 32'(busy), 32'h0);
    check_model("break release");

    // One-cycle glitch while idle.
    tick(2 * Cpb);
    saw_busy = 1'b0;
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    for (int k = 0; k < Cpb / 2 + 3; k++) begin
      tick(1);
      if (busy) saw_busy = 1'b1;
    end
    chk("glitch busy seen", 32'(saw_busy), 32'h1);
    chk("glitch busy cleared", 32'(busy), 32'h0);
    tick(2 * Cpb);
    check_model("glitch");

    // Back-to-back frames, no idle between them.
    send_frame(4'hA, 1'b0, 1'b1, 0);
    send_frame(4'h5, 1'b0, 1'b1, 2);
    model_frame(4'hA, 1'b0, 1'b1);
    model_frame(4'h5, 1'b0, 1'b1);
    check_model("b2b");
    chk("b2b valid spacing", vcyc_last - vcyc_prev, 7 * Cpb);
    chk("b2b first data", 32'(vdat_prev), 32'hA);
    chk("b2b second data", 32'(vdat_last), 32'h5);

    // Reset in the middle of the data bits.
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst_n = 1'b0;
    rx    = 1'b1;
    tick(1);
    check_reset_outputs("mid-frame reset");
    rst_n  = 1'b1;
    m_data = 4'h0;
    m_par  = 1'b0;
    m_perr = 1'b0;
    tick(3 * Cpb);
    check_model("after reset idle");
    send_frame(4'hC, 1'b0, 1'b1, 2);
    model_frame(4'hC, 1'b0, 1'b1);
    check_model("after reset frame");

    // Randomized frames against the model.
    for (int n = 0; n < 30; n++) begin
      rd = 4'($urandom_range(0, 15));
      rp = 1'($urandom_range(0, 1));
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rd, rp, rs, int'($urandom_range(2, 3)));
      model_frame(rd, rp, rs);
      check_model($sformatf("rnd%0d", n));
    end

    chk("valid with frame_err", nboth, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_parity_rx.md
# serial_parity_rx

Serial receiver that deframes a 4-bit data nibble plus its even-parity bit from a single-wire asynchronous line. It presents them as a parallel word with a one-cycle valid strobe. It sits directly upstream of the even parity checker: `data_out`/`parity_out` connect straight to the checker's `data`/`parity` inputs, and `valid` qualifies the checker's `error` output. Frame format, line idle high: start(0), d0..d3 LSB-first, parity, stop(1).

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16. Clock cycles per bit period. Legal range is ≥4 and even.

Ports:
- `clk`, input, 1. Single clock; all logic is rising-edge.
- `rst_n`, input, 1. Reset is synchronous and active-low.
- `rx`, input, 1. Asynchronous serial line, idle high.
- `data_out`, output, 4. Received nibble, d3..d0. Holds its value until the next good frame.
- `parity_out`, output, 1. Received parity bit. Holds its value until the next good frame.
- `valid`, output, 1. One-cycle pulse when `data_out`/`parity_out` update.
- `frame_err`, output, 1. One-cycle pulse when the stop bit is sampled 0.
- `busy`, output, 1. High in any state other than IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer to produce `rx_s`. All decisions use `rx_s`.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- **IDLE**: when `rx_s`=0, go to START and clear the bit-period counter.
- **START**: at count CLKS_PER_BIT/2−1 (mid-bit), sample `rx_s`.
  - 0: go to DATA, restart the counter, clear the bit index.
  - 1: glitch. Return to IDLE with no outputs.
- **DATA**: every CLKS_PER_BIT cycles, sample `rx_s` into shift register bit [index], LSB first. After index 3, go to PARITY.
- **PARITY**: sample after CLKS_PER_BIT cycles into the parity register, then go to STOP.
- **STOP**: sample after CLKS_PER_BIT cycles.
  - 1: load `data_out`/`parity_out`, pulse `valid`, go to IDLE.
  - 0: pulse `frame_err`, leave `data_out`/`parity_out` unchanged, go to BREAK.
- **BREAK**: wait for `rx_s`=1, then go to IDLE. This prevents a stuck-low line from retriggering continuously.
- The parity value is passed through unchecked. Checking is the downstream stage's job, unless the Configuration feature below is enabled.
- The counter width is $clog2(CLKS_PER_BIT). It wraps to 0 at CLKS_PER_BIT−1.

## Timing
- Reset values: `data_out`=4'h0, `parity_out`=0, `valid`=0, `frame_err`=0, `busy`=0. FSM in IDLE, synchronizer flops = 1.
- Reset mid-frame returns to IDLE on the next edge. The partial frame is discarded and no strobe is issued.
- Synchronizer latency is 2 cycles from an `rx` edge to `rx_s`.
- Every sample lands at the bit midpoint: CLKS_PER_BIT/2 cycles after the start edge seen on `rx_s`, plus k·CLKS_PER_BIT.
- `valid` and `frame_err` are registered. They assert in the cycle after the stop-bit sample and are never high together.
- Back-to-back frames: a start edge arriving in the cycle `valid` is high is detected. IDLE is entered on that same edge, so the minimum gap is 0 idle bits beyond the stop bit.
- `busy` rises one cycle after `rx_s` falls in IDLE.

## Configuration
- `SERIAL_PARITY_RX_CHECK_EN` defined: adds output `parity_err` (1 bit, reset 0).
  - It is registered alongside `valid` and equals XOR(d3..d0, parity) for the accepted frame.
  - Its value holds until the next good frame.
- Undefined: the port and its XOR are absent, and the checker downstream is the only parity check.

## Structure
- Shared package `serial_parity_pkg`:
  - FSM state enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - Constants `FRAME_DATA_BITS`=4 and `RX_IDLE_LEVEL`=1'b1.
- One sub-module, `sync_2ff`: a 1-bit, two-stage synchronizer with synchronous active-low reset and parameterized reset value. It is reused for other async inputs.

## Test plan
All scenarios use CLKS_PER_BIT=4.
- Frame d=4'b1011, parity=1, stop=1 → one `valid` pulse; `data_out`=4'hB, `parity_out`=1; `frame_err`=0 throughout.
- Frame d=4'h6, parity=1 (wrong parity) → `valid` pulse; `data_out`=4'h6, `parity_out`=1.
  - With `SERIAL_PARITY_RX_CHECK_EN`: `parity_err`=1 together with `valid`.
- Frame d=4'h3, stop=0, then line held low for 20 cycles → `frame_err` pulse; `data_out` keeps its previous value; no `valid`; FSM stays in BREAK until the line goes high, with no retrigger.
- 1-cycle low glitch on `rx` while idle → no `valid`/`frame_err`; `busy` returns to 0 within CLKS_PER_BIT/2+3 cycles.
- Two frames back-to-back (4'hA then 4'h5, zero idle) → two `valid` pulses exactly 7·CLKS_PER_BIT=28 cycles apart, with the correct data for each.
- `rst_n`=0 for one cycle during DATA → all outputs at reset values; the next complete frame (4'hC) is received correctly.
